// File: rtl/gcode_pkg.sv
// gcode_pkg: command encoding, command word layout and mode bit positions shared by the sequencer
package gcode_pkg;
  localparam int COORD_W = 16;
  typedef enum logic [3:0] {
    G00 = 4'd0, G01 = 4'd1, G20 = 4'd2, G21 = 4'd3, G90 = 4'd4,
    G91 = 4'd5, M2 = 4'd6, M6 = 4'd7, M72 = 4'd8
  } cmd_code_e;
  // cmd is a raw nibble so that illegal codes 9-15 can still be carried and flagged
  typedef struct packed {
    logic [3:0] cmd;
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } gcode_cmd_t;
  typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT_MOVE, TOOL, HALT} state_e;
  localparam int MODE_LINEAR = 0;
  localparam int MODE_INCHES = 1;
  localparam int MODE_ABSOLUTE = 2;
  localparam int MODE_RAISE = 3;
  localparam int MODE_TOOL = 4;
  localparam logic [4:0] MODE_RESET = 5'b00100;
endpackage

// File: rtl/gcode_target_calc.sv
// gcode_target_calc: resolves a move target from absolute or position-relative coordinates
module gcode_target_calc
  import gcode_pkg::*;
(
  input  logic                      absolute,
  input  logic signed [COORD_W-1:0] pos_x,
  input  logic signed [COORD_W-1:0] pos_y,
  input  logic signed [COORD_W-1:0] x,
  input  logic signed [COORD_W-1:0] y,
  output logic signed [COORD_W-1:0] tgt_x,
  output logic signed [COORD_W-1:0] tgt_y
);
  // relative sums wrap at the coordinate width by construction
  assign tgt_x = absolute ? x : pos_x + x;
  assign tgt_y = absolute ? y : pos_y + y;
endmodule

// File: rtl/gcode_sequencer.sv
// gcode_sequencer: fetches one command at a time, tracks modal state and issues moves/tool changes
module gcode_sequencer
  import gcode_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  gcode_cmd_t                cmd_in,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic                      move_valid,
  input  logic                      move_ready,
  output logic signed [COORD_W-1:0] move_x,
  output logic signed [COORD_W-1:0] move_y,
  output logic                      move_linear,
  input  logic                      move_done,
  output logic                      tool_req,
  input  logic                      tool_ack,
  output logic [4:0]                mode_reg,
  output logic                      halted,
  output logic                      error
);
  state_e state_q, state_d;
  gcode_cmd_t cmd_q, cmd_d;
  logic [4:0] mode_q, mode_d;
  logic signed [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [COORD_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic signed [COORD_W-1:0] calc_x, calc_y;
  logic error_q, error_d;
  logic cmd_ready_q, move_valid_q, tool_req_q, halted_q;

  gcode_target_calc u_target (
    .absolute(mode_q[MODE_ABSOLUTE]),
    .pos_x   (pos_x_q),
    .pos_y   (pos_y_q),
    .x       (cmd_q.x),
    .y       (cmd_q.y),
    .tgt_x   (calc_x),
    .tgt_y   (calc_y)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        cmd_d   = cmd_in;
        state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        case (cmd_q.cmd)
          G00, G01: begin
            mode_d[MODE_LINEAR] = cmd_q.cmd[0];
            mode_d[MODE_TOOL]   = 1'b0;
            mode_d[MODE_RAISE]  = 1'b0;
            tgt_x_d = calc_x;
            tgt_y_d = calc_y;
            state_d = ISSUE;
          end
          G20: mode_d[MODE_INCHES] = 1'b1;
          G21: mode_d[MODE_INCHES] = 1'b0;
          G90: mode_d[MODE_ABSOLUTE] = 1'b1;
          G91: mode_d[MODE_ABSOLUTE] = 1'b0;
          M72: mode_d[MODE_RAISE] = 1'b1;
          M2:  state_d = HALT;
          M6: begin
            mode_d[MODE_TOOL] = 1'b1;
            state_d = TOOL;
          end
          default: error_d = 1'b1;
        endcase
      end
      ISSUE: if (move_ready) begin
        pos_x_d = tgt_x_q;
        pos_y_d = tgt_y_q;
        state_d = WAIT_MOVE;
      end
      WAIT_MOVE: state_d = move_done ? IDLE : WAIT_MOVE;
      TOOL:      state_d = tool_ack ? IDLE : TOOL;
      HALT:      state_d = HALT;
      default:   state_d = IDLE;
    endcase
  end

  // handshake outputs are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      mode_q       <= MODE_RESET;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      tgt_x_q      <= '0;
      tgt_y_q      <= '0;
      error_q      <= 1'b0;
      cmd_ready_q  <= 1'b0;
      move_valid_q <= 1'b0;
      tool_req_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      mode_q       <= mode_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      tgt_x_q      <= tgt_x_d;
      tgt_y_q      <= tgt_y_d;
      error_q      <= error_d;
      cmd_ready_q  <= state_d == IDLE;
      move_valid_q <= state_d == ISSUE;
      tool_req_q   <= state_d == TOOL;
      halted_q     <= state_d == HALT;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign move_valid  = move_valid_q;
  assign move_x      = tgt_x_q;
  assign move_y      = tgt_y_q;
  assign move_linear = mode_q[MODE_LINEAR];
  assign tool_req    = tool_req_q;
  assign mode_reg    = mode_q;
  assign halted      = halted_q;
  assign error       = error_q;
endmodule

// File: tb/tb_gcode_sequencer.sv
// tb_gcode_sequencer: directed vector table, randomized commands against a transaction-level model, and reset/halt corners
module tb_gcode_sequencer;
  import gcode_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  gcode_cmd_t cmd_in = '0;
  logic cmd_valid = 1'b0, move_ready = 1'b0, move_done = 1'b0, tool_ack = 1'b0;
  logic cmd_ready, move_valid, move_linear, tool_req, halted, error;
  logic signed [COORD_W-1:0] move_x, move_y;
  logic [4:0] mode_reg;
  int checks = 0;
  int failures = 0;

  shortint px, py;
  bit m_tool, m_raise, m_abs, m_inch, m_lin, m_err;

  gcode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .move_valid(move_valid), .move_ready(move_ready), .move_x(move_x), .move_y(move_y),
    .move_linear(move_linear), .move_done(move_done), .tool_req(tool_req), .tool_ack(tool_ack),
    .mode_reg(mode_reg), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_mode();
    return {27'd0, m_tool, m_raise, m_abs, m_inch, m_lin};
  endfunction

  task automatic model_reset();
    px = 0; py = 0;
    {m_tool, m_raise, m_abs, m_inch, m_lin, m_err} = 6'b001000;
  endtask

  // kind: 0 mode-only/illegal, 1 move, 2 tool change, 3 halt
  task automatic model_apply(input logic [3:0] c, input shortint x, input shortint y,
                             output int kind, output shortint tx, output shortint ty);
    kind = 0; tx = 0; ty = 0;
    if (c <= 4'd1) begin
      m_lin = c[0]; m_tool = 0; m_raise = 0;
      tx = m_abs ? x : px + x;
      ty = m_abs ? y : py + y;
      kind = 1;
    end
    else if (c == 4'd2) m_inch = 1;
    else if (c == 4'd3) m_inch = 0;
    else if (c == 4'd4) m_abs = 1;
    else if (c == 4'd5) m_abs = 0;
    else if (c == 4'd6) kind = 3;
    else if (c == 4'd7) begin m_tool = 1; kind = 2; end
    else if (c == 4'd8) m_raise = 1;
    else m_err = 1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_move_valid", move_valid, 0);
    chk("rst_tool_req", tool_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_mode", mode_reg, 5'b00100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    chk("rst_first_edge_ready", cmd_ready, 1);
    model_reset();
  endtask

  task automatic send(input logic [3:0] c, input shortint x, input shortint y);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_in = '{cmd: c, x: x, y: y};
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_in = '{cmd: 4'($urandom), x: 16'($urandom), y: 16'($urandom)};
    chk("decode_ready_low", cmd_ready, 0);
    chk("decode_no_move", move_valid, 0);
  endtask

  task automatic run_cmd(input logic [3:0] c, input shortint x, input shortint y, input int dly,
                         output shortint mx, output shortint my);
    int kind, n;
    shortint tx, ty;
    send(c, x, y);
    model_apply(c, x, y, kind, tx, ty);
    @(posedge clk); #1;
    mx = move_x; my = move_y;
    if (kind == 1) begin
      chk("move_valid", move_valid, 1);
      chk("move_x", move_x, tx);
      chk("move_y", move_y, ty);
      chk("move_linear", move_linear, int'(m_lin));
      for (int i = 0; i < dly; i++) begin
        move_done = 1'($urandom); tool_ack = 1'($urandom);
        @(posedge clk); #1;
        chk("stall_valid", move_valid, 1);
        chk("stall_x", move_x, tx);
        chk("stall_y", move_y, ty);
      end
      move_done = 1'b0; tool_ack = 1'b0; move_ready = 1'b1;
      @(posedge clk); #1;
      move_ready = 1'b0;
      chk("move_valid_drop", move_valid, 0);
      px = tx; py = ty;
      n = $urandom_range(0, 3);
      repeat (n) begin
        tool_ack = 1'($urandom);
        @(posedge clk); #1;
        chk("wait_ready_low", cmd_ready, 0);
      end
      tool_ack = 1'b0; move_done = 1'b1;
      @(posedge clk); #1;
      move_done = 1'b0;
      chk("done_ready", cmd_ready, 1);
    end else if (kind == 2) begin
      chk("tool_req", tool_req, 1);
      chk("tool_ready_low", cmd_ready, 0);
      for (int i = 1; i < dly; i++) begin
        move_done = 1'($urandom);
        @(posedge clk); #1;
        chk("tool_req_hold", tool_req, 1);
        chk("tool_ready_hold", cmd_ready, 0);
      end
      move_done = 1'b0; tool_ack = 1'b1;
      @(posedge clk); #1;
      tool_ack = 1'b0;
      chk("tool_req_drop", tool_req, 0);
      chk("tool_done_ready", cmd_ready, 1);
    end else if (kind == 3) begin
      chk("halted", halted, 1);
      chk("halt_ready_low", cmd_ready, 0);
    end else begin
      chk("mode_cmd_ready", cmd_ready, 1);
    end
    chk("mode_reg", mode_reg, model_mode());
    chk("error", error, int'(m_err));
  endtask

  typedef struct {
    int c, x, y, dly, mv, ex, ey, em, ee;
  } vec_t;
  vec_t tbl[15];

  initial begin
    shortint mx, my;
    int r;
    tbl[0]  = '{5, 0, 0, 0, 0, 0, 0, 5'b00000, 0};
    tbl[1]  = '{1, 10, -5, 0, 1, 10, -5, 5'b00001, 0};
    tbl[2]  = '{1, 10, -5, 2, 1, 20, -10, 5'b00001, 0};
    tbl[3]  = '{4, 0, 0, 0, 0, 0, 0, 5'b00101, 0};
    tbl[4]  = '{0, 3, 4, 5, 1, 3, 4, 5'b00100, 0};
    tbl[5]  = '{5, 0, 0, 0, 0, 0, 0, 5'b00000, 0};
    tbl[6]  = '{1, -2, -4, 1, 1, 1, 0, 5'b00001, 0};
    tbl[7]  = '{1, 32767, 0, 0, 1, -32768, 0, 5'b00001, 0};
    tbl[8]  = '{12, 0, 0, 0, 0, 0, 0, 5'b00001, 1};
    tbl[9]  = '{2, 0, 0, 0, 0, 0, 0, 5'b00011, 1};
    tbl[10] = '{3, 0, 0, 0, 0, 0, 0, 5'b00001, 1};
    tbl[11] = '{8, 0, 0, 0, 0, 0, 0, 5'b01001, 1};
    tbl[12] = '{0, 0, 0, 0, 1, -32768, 0, 5'b00000, 1};
    tbl[13] = '{7, 0, 0, 7, 0, 0, 0, 5'b10000, 1};
    tbl[14] = '{0, 5, 5, 0, 1, -32763, 5, 5'b00000, 1};

    do_reset();
    foreach (tbl[i]) begin
      run_cmd(4'(tbl[i].c), shortint'(tbl[i].x), shortint'(tbl[i].y), tbl[i].dly, mx, my);
      if (tbl[i].mv != 0) begin
        chk("tbl_x", mx, tbl[i].ex);
        chk("tbl_y", my, tbl[i].ey);
      end
      chk("tbl_mode", mode_reg, tbl[i].em);
      chk("tbl_err", error, tbl[i].ee);
    end

    do_reset();
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 14);
      run_cmd(4'(r < 6 ? r : r + 1), shortint'($urandom), shortint'($urandom),
              $urandom_range(1, 6), mx, my);
    end

    // reset while a move is in flight must abandon it without replay
    do_reset();
    send(4'd1, 16'sd7, 16'sd8);
    @(posedge clk); #1;
    chk("inflight_valid", move_valid, 1);
    chk("inflight_x", move_x, 7);
    move_ready = 1'b1;
    @(posedge clk); #1;
    move_ready = 1'b0;
    chk("inflight_wait", move_valid, 0);
    do_reset();
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_replay", move_valid, 0);
    end
    run_cmd(4'd5, 0, 0, 0, mx, my);
    run_cmd(4'd1, 16'sd1, 16'sd1, 1, mx, my);

    run_cmd(4'd6, 0, 0, 0, mx, my);
    cmd_in = '{cmd: 4'd4, x: 16'sd0, y: 16'sd0};
    cmd_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("halt_ready", cmd_ready, 0);
      chk("halt_hold", halted, 1);
    end
    cmd_valid = 1'b0;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gcode_sequencer.md
GCODE_SEQUENCER -- requirements
Module: gcode_sequencer

Interface
REQ-001 COORD_W, 16, signed coordinate width in bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_in  input  command (gcode_pkg struct: cmd, x, y)  command word from program memory.
REQ-005 cmd_valid  input  1  memory presents a valid cmd_in.
REQ-006 cmd_ready  output  1  sequencer accepts cmd_in this cycle.
REQ-007 move_valid  output  1  move request to motion controller.
REQ-008 move_ready  input  1  motion controller accepts the move.
REQ-009 move_x, move_y  output  COORD_W each  absolute move target.
REQ-010 move_linear  output  1  1 = linear (G01), 0 = rapid (G00).
REQ-011 move_done  input  1  single-cycle pulse: accepted move finished.
REQ-012 tool_req  output  1  tool-change request; tool_ack  input  1  tool change complete.
REQ-013 mode_reg  output  5  {tool_change, raise_tool, absolute, inches, linear}.
REQ-014 halted  output  1  program ended (M2).
REQ-015 error  output  1  sticky; illegal command code seen.

Function
REQ-016 FSM states SHALL be IDLE, DECODE, ISSUE, WAIT_MOVE, TOOL and HALT.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a handshake (cmd_valid & cmd_ready) latches cmd_in and moves to DECODE.
REQ-018 DECODE SHALL last exactly one cycle; mode_reg updates on the edge leaving DECODE.
REQ-019 G20/G21 set/clear inches, G90/G91 set/clear absolute, M72 sets raise_tool; each returns to IDLE.
REQ-020 G00/G01 clear/set linear, clear tool_change and raise_tool, compute target, then go to ISSUE.
REQ-021 Target SHALL be (x,y) when absolute=1, else (pos_x+x, pos_y+y), wrapping modulo 2^COORD_W with no saturation.
REQ-022 ISSUE: move_valid=1; move_x, move_y and move_linear stay stable until move_ready; on handshake pos <= target and the FSM goes to WAIT_MOVE.
REQ-023 WAIT_MOVE: on move_done go to IDLE; move_done in any other state SHALL be ignored.
REQ-024 M6 sets tool_change and goes to TOOL; tool_req=1 until tool_ack, then go to IDLE; tool_ack outside TOOL is ignored.
REQ-025 M2 goes to HALT: halted=1, cmd_ready=0; only reset exits HALT.
REQ-026 Codes 9-15 set error, discard the command, and return to IDLE with no mode change.
REQ-027 Minimum spacing between accepted mode-only commands SHALL be 2 cycles; move_valid SHALL rise the cycle after DECODE.
REQ-028 The sequencer has no internal queue; at most one command is in flight.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, pos=0 and mode_reg=5'b00100 (absolute, mm, rapid), and clear move_valid, tool_req, halted, error and cmd_ready.
REQ-030 Reset during ISSUE, WAIT_MOVE or TOOL SHALL abandon the operation; no request is replayed after reset.
REQ-031 cmd_ready SHALL rise the first clock edge after rst_n deasserts.

Structure
REQ-032 gcode_pkg SHALL hold:
- the cmd_code enum (G00=0, G01=1, G20=2, G21=3, G90=4, G91=5, M2=6, M6=7, M72=8; 4 bits);
- the command struct;
- the mode_reg bit-index constants;
- COORD_W default.
REQ-033 Absolute/relative target resolution SHALL be one combinational sub-module, gcode_target_calc.

Verification
REQ-034 Reset, then G91, then G01 x=10 y=-5 twice -> targets (10,-5) then (20,-10); move_linear=1; mode_reg=5'b00001.
REQ-035 G90 with pos=(20,-10), then G00 x=3 y=4; hold move_ready=0 for 5 cycles -> move_valid held, data stable at (3,4); one transfer on ready.
REQ-036 M6 with tool_ack delayed 7 cycles -> tool_req high 7 cycles, cmd_ready=0 throughout; mode_reg[4]=1; next G00 clears it.
REQ-037 Relative G01 x=32767 from pos_x=1 -> move_x=-32768 (wrap); cmd code 12 -> error=1, mode unchanged.
REQ-038 M2 -> halted=1, cmd_ready stays 0 for 20 cycles despite cmd_valid; reset asserted mid-WAIT_MOVE -> all outputs at reset values immediately.
